eth_tx_framer: RTL
==================

Name: eth_tx_framer

Overview:
Byte-wide Ethernet transmit MAC framer. It sits between a packet source and the RGMII TX DDR glue, and runs in the tx_clk domain. It takes a payload byte stream with valid/ready/last handshaking and sequences each frame as preamble, SFD, payload, zero pad, FCS (CRC-32) and inter-packet gap. It drives the glue's tx_en/tx_err/tx_data inputs.

Parameters:
IPG_BYTES, 12, idle byte-times forced after each frame (tx_en=0); minimum 1.
MIN_FRAME, 60, minimum bytes after SFD excluding FCS; shorter payloads are zero-padded to this length.
PAD_EN, 1, 1=pad short frames, 0=no padding.

Ports:
tx_clk  in  1  transmit byte clock (125 MHz at gigabit); sole clock.
tx_rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  payload byte valid.
in_ready  out  1  framer accepts in_data this cycle.
in_data  in  8  payload byte (destination MAC first).
in_last  in  1  marks final payload byte of the frame.
tx_en  out  1  to RGMII glue tx_en.
tx_err  out  1  to RGMII glue tx_err.
tx_data  out  8  to RGMII glue tx_data.
busy  out  1  high from frame start through end of IPG.
frame_done  out  1  one-cycle pulse on the last IPG cycle of a good frame.
underrun  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset (async assert, sync release): state IDLE; tx_en=0, tx_err=0, tx_data=0, in_ready=0, busy=0, frame_done=0, underrun=0; CRC=0xFFFFFFFF; counters=0.
- tx_en, tx_err, tx_data, busy, frame_done and underrun are registered. in_ready is combinational from state only.
- States: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, ABORT, IPG.
- IDLE: in_valid=1 sampled at cycle 0 -> PREAMBLE. The frame is never started without in_valid.
- PREAMBLE: cycles 1..7 drive tx_en=1, tx_data=0x55.
- SFD: cycle 8 drives 0xD5. in_ready=1 in SFD and PAYLOAD.
- Acceptance: a byte accepted (in_valid&in_ready) in cycle n appears on tx_data in cycle n+1. Cycle 8 therefore accepts the first payload byte, which is driven in cycle 9.
- PAYLOAD, in_valid=0 while in_ready=1 (underrun):
  - next cycle drives tx_en=1, tx_err=1, tx_data=0x00 (ABORT, one cycle);
  - underrun pulses with ABORT;
  - then IPG with no FCS;
  - frame_done does not pulse.
- PAYLOAD, in_last accepted: in_ready drops the next cycle. If PAD_EN and byte count < MIN_FRAME, go to PAD; otherwise go to FCS.
- Byte count: 16-bit, saturating at 0xFFFF. No maximum-length check.
- PAD: drives 0x00 until count == MIN_FRAME. Pad bytes are included in the CRC.
- CRC:
  - reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF;
  - updated on every driven payload and pad byte;
  - not updated on preamble or SFD.
- FCS: 4 cycles driving ~crc, LSB byte first (bits 7:0, 15:8, 23:16, 31:24). The CRC register is frozen during FCS.
- IPG:
  - tx_en=0, tx_data=0 for exactly IPG_BYTES cycles;
  - CRC reinitialised on entry;
  - frame_done pulses on the final IPG cycle if no abort occurred;
  - then IDLE.
- Back-to-back: in_valid held high during IPG starts the next preamble the cycle after IDLE is entered. The gap is IPG_BYTES+1 cycles of tx_en=0.
- tx_err=1 only in ABORT.
- busy=1 in every state except IDLE.
- Reset mid-frame: outputs go to reset values immediately (async), with no FCS or abort byte. Any partial payload byte in flight is dropped.

Decomposition:
- Package eth_pkg holds:
  - ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5;
  - ETH_CRC_POLY=32'hEDB88320, ETH_CRC_INIT=32'hFFFFFFFF, ETH_CRC_RESIDUE=32'hDEBB20E3;
  - the tx state enum eth_tx_state_t.
- Sub-module eth_crc32_d8 is a combinational next-CRC function: crc_in[31:0], d[7:0] -> crc_out[31:0]. It is reused by the future RX path.

Test Plan:
- Single byte 0x01, in_last=1:
  - tx_en high for exactly 72 cycles (8 preamble/SFD, 1 payload, 59 pad, 4 FCS);
  - cycles 1-7 carry 0x55, cycle 8 carries 0xD5, cycle 9 carries 0x01;
  - CRC over all post-SFD bytes, including FCS, yields register residue 0xDEBB20E3;
  - frame_done pulses after 12 idle cycles.
- 64-byte frame of 0x00..0x3F: no PAD state; 68 post-SFD bytes; FCS matches the software CRC-32 reference; in_ready high for exactly 64 accepting cycles.
- Two 60-byte frames, in_valid held high: the second preamble starts exactly 13 cycles after the first frame's last FCS byte; both residues are correct.
- Underrun: in_valid dropped after 10 payload bytes:
  - next cycle tx_en=1, tx_err=1, tx_data=0x00;
  - then tx_en=0 for 12 cycles;
  - underrun pulses once; frame_done never pulses.
- Assert tx_rst_n low during payload byte 20:
  - all outputs are 0 immediately;
  - after release with in_valid=0, the framer stays IDLE;
  - a subsequent 1-byte frame is correct (CRC reinitialised).
- PAD_EN=0 build, 1-byte frame: tx_en high for 13 cycles; FCS equals CRC-32 of {0x01} = 0xA505DF1B, sent as bytes 1B DF 05 A5.

Source files
------------

// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared Ethernet constants and the transmit framer state type.
// Used by eth_tx_framer and eth_crc32_d8 (and later by the RX path).
// -----------------------------------------------------------------------------
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

    // Preamble bytes (0x55) sent before the SFD.
    localparam logic [15:0] ETH_PREAMBLE_LEN = 16'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_ABORT,
        ST_IPG
    } eth_tx_state_t;

endpackage

// File: rtl/eth_crc32_d8.sv
// -----------------------------------------------------------------------------
// eth_crc32_d8
// Combinational one-byte step of the reflected Ethernet CRC-32
// (poly 0xEDB88320). Data bits are consumed LSB first.
//   crc_in  [31:0] : current CRC register value
//   d       [7:0]  : data byte
//   crc_out [31:0] : CRC register value after absorbing d
// -----------------------------------------------------------------------------
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] w_c;
        w_c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (w_c[0] ^ d[i]) begin
                w_c = (w_c >> 1) ^ ETH_CRC_POLY;
            end else begin
                w_c = w_c >> 1;
            end
        end
        crc_out = w_c;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// -----------------------------------------------------------------------------
// eth_tx_framer
// Byte-wide Ethernet transmit framer feeding the RGMII TX DDR glue.
// Frame: 7x preamble, SFD, payload, optional zero pad, 4-byte FCS, IPG.
// Ports:
//   tx_clk, tx_rst_n          : byte clock, async active-low reset
//   in_valid/in_ready/in_data/in_last : payload byte stream
//   tx_en, tx_err, tx_data    : registered outputs to the RGMII glue
//   busy                      : frame start through end of IPG
//   frame_done                : pulse on last IPG cycle of a good frame
//   underrun                  : pulse when a frame is aborted
// -----------------------------------------------------------------------------
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned IPG_BYTES = 12,
    parameter int unsigned MIN_FRAME = 60,
    parameter bit          PAD_EN    = 1'b1
) (
    input  logic       tx_clk,
    input  logic       tx_rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       tx_en,
    output logic       tx_err,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [15:0] IPG_CNT = 16'(IPG_BYTES);
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);

    // The state names the decision taken at the next clock edge; the output
    // registers hold the byte on the wire. After the last payload byte is
    // accepted, the state moves on (PAD/FCS) while that byte is still on the
    // wire, so in_ready can be decoded from the state alone.
    eth_tx_state_t r_state, w_state_nxt;

    logic [15:0] r_cnt, w_cnt_nxt;            // preamble / FCS / IPG position
    logic [15:0] r_byte_cnt, w_byte_cnt_nxt;  // bytes after SFD, saturating
    logic [31:0] r_crc, w_crc_nxt;
    logic        r_aborted, w_aborted_nxt;

    logic        r_tx_en, w_tx_en_nxt;
    logic        r_tx_err, w_tx_err_nxt;
    logic [7:0]  r_tx_data, w_tx_data_nxt;
    logic        r_busy;
    logic        r_frame_done, w_frame_done_nxt;
    logic        r_underrun, w_underrun_nxt;

    logic [7:0]  w_crc_byte;
    logic [31:0] w_crc_upd;
    logic [31:0] w_fcs;
    logic [15:0] w_byte_cnt_inc;

    // Pad bytes are zero; everything else absorbed into the CRC is in_data.
    assign w_crc_byte     = (r_state == ST_PAD) ? 8'h00 : in_data;
    assign w_fcs          = ~r_crc;
    assign w_byte_cnt_inc = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;

    eth_crc32_d8 u_crc (
        .crc_in  (r_crc),
        .d       (w_crc_byte),
        .crc_out (w_crc_upd)
    );

    assign in_ready = (r_state == ST_SFD) || (r_state == ST_PAYLOAD);

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_crc_nxt        = r_crc;
        w_aborted_nxt    = r_aborted;
        w_tx_en_nxt      = 1'b0;
        w_tx_err_nxt     = 1'b0;
        w_tx_data_nxt    = 8'h00;
        w_frame_done_nxt = 1'b0;
        w_underrun_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt    = ST_PREAMBLE;
                    w_cnt_nxt      = 16'd1;
                    w_byte_cnt_nxt = '0;
                    w_aborted_nxt  = 1'b0;
                    w_tx_en_nxt    = 1'b1;
                    w_tx_data_nxt  = ETH_PREAMBLE;
                end
            end

            ST_PREAMBLE: begin
                w_tx_en_nxt = 1'b1;
                if (r_cnt >= ETH_PREAMBLE_LEN) begin
                    w_state_nxt   = ST_SFD;
                    w_cnt_nxt     = '0;
                    w_tx_data_nxt = ETH_SFD;
                end else begin
                    w_cnt_nxt     = r_cnt + 16'd1;
                    w_tx_data_nxt = ETH_PREAMBLE;
                end
            end

            ST_SFD, ST_PAYLOAD: begin
                w_tx_en_nxt = 1'b1;
                if (in_valid) begin
                    w_tx_data_nxt  = in_data;
                    w_crc_nxt      = w_crc_upd;
                    w_byte_cnt_nxt = w_byte_cnt_inc;
                    if (in_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (PAD_EN && (w_byte_cnt_inc < MIN_LEN)) ? ST_PAD : ST_FCS;
                    end else begin
                        w_state_nxt = ST_PAYLOAD;
                    end
                end else begin
                    w_state_nxt    = ST_ABORT;
                    w_tx_err_nxt   = 1'b1;
                    w_underrun_nxt = 1'b1;
                    w_aborted_nxt  = 1'b1;
                end
            end

            ST_PAD: begin
                w_tx_en_nxt    = 1'b1;
                w_crc_nxt      = w_crc_upd;
                w_byte_cnt_nxt = w_byte_cnt_inc;
                if (w_byte_cnt_inc >= MIN_LEN) begin
                    w_state_nxt = ST_FCS;
                    w_cnt_nxt   = '0;
                end
            end

            ST_FCS: begin
                w_tx_en_nxt = 1'b1;
                case (r_cnt[1:0])
                    2'd0:    w_tx_data_nxt = w_fcs[7:0];
                    2'd1:    w_tx_data_nxt = w_fcs[15:8];
                    2'd2:    w_tx_data_nxt = w_fcs[23:16];
                    default: w_tx_data_nxt = w_fcs[31:24];
                endcase
                if (r_cnt >= 16'd3) begin
                    w_state_nxt = ST_IPG;
                    w_cnt_nxt   = '0;
                    w_crc_nxt   = ETH_CRC_INIT;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            // The abort edge already drives the first idle byte, so the
            // IPG count starts at one to keep the gap length the same.
            ST_ABORT: begin
                w_state_nxt = ST_IPG;
                w_cnt_nxt   = 16'd1;
                w_crc_nxt   = ETH_CRC_INIT;
            end

            ST_IPG: begin
                if (r_cnt >= IPG_CNT) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt        = r_cnt + 16'd1;
                    w_frame_done_nxt = ((r_cnt + 16'd1) == IPG_CNT) && !r_aborted;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_byte_cnt   <= '0;
            r_crc        <= ETH_CRC_INIT;
            r_aborted    <= 1'b0;
            r_tx_en      <= 1'b0;
            r_tx_err     <= 1'b0;
            r_tx_data    <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_crc        <= w_crc_nxt;
            r_aborted    <= w_aborted_nxt;
            r_tx_en      <= w_tx_en_nxt;
            r_tx_err     <= w_tx_err_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_frame_done <= w_frame_done_nxt;
            r_underrun   <= w_underrun_nxt;
        end
    end

    assign tx_en      = r_tx_en;
    assign tx_err     = r_tx_err;
    assign tx_data    = r_tx_data;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;

endmodule
